// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: ALU shift modes and controller states.
package shift_pkg;

  typedef enum logic [1:0] {
    ALU_SLL = 2'b00,
    ALU_SRL = 2'b01,
    ALU_ROR = 2'b10,
    ALU_SRA = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves acc by 0..STEP positions in the given mode.
// Rotate-right is built only when ITER_SHIFTER_ROTATE_EN is defined; otherwise ROR acts as SRL.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  localparam int unsigned AW   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [AW-1:0]    amt_i,
  input  alu_op_t          mode_i,
  output logic [WIDTH-1:0] res_o
);

  always_comb begin
    res_o = acc_i >> amt_i;
    case (mode_i)
      ALU_SLL: res_o = acc_i << amt_i;
      ALU_SRL: res_o = acc_i >> amt_i;
      // Arithmetic shift replicates the current MSB of acc on every step.
      ALU_SRA: res_o = WIDTH'($signed(acc_i) >>> amt_i);
`ifdef ITER_SHIFTER_ROTATE_EN
      ALU_ROR: res_o = WIDTH'({acc_i, acc_i} >> amt_i);
`else
      ALU_ROR: res_o = acc_i >> amt_i;
`endif
      default: res_o = acc_i >> amt_i;
    endcase
  end

endmodule : shift_step

// File: rtl/iter_shifter.sv
// Multi-cycle barrel-shift replacement: shifts at most STEP positions per cycle until shamt is consumed.
// Optional rotate-right support is enabled with the ITER_SHIFTER_ROTATE_EN macro.
module iter_shifter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         b,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [1:0]               alufun,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         y
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = $clog2(STEP) + 1;

  state_t           state_q;
  alu_op_t          mode_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    step_amt;
  logic             last_step;
  logic             busy_q, done_q;

  // Final step consumes whatever remains of the count (possibly zero).
  always_comb begin
    last_step = (cnt_q < CW'(STEP));
    step_amt  = last_step ? AW'(cnt_q) : AW'(STEP);
    cnt_d     = last_step ? '0 : cnt_q - CW'(STEP);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .acc_i  (acc_q),
    .amt_i  (step_amt),
    .mode_i (mode_q),
    .res_o  (acc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= ALU_SLL;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            acc_q   <= b;
            cnt_q   <= shamt;
            mode_q  <= alu_op_t'(alufun);
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        // start is deliberately not looked at while shifting.
        ST_SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (last_step) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = acc_q;

endmodule : iter_shifter

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter (WIDTH=32, STEP=4): directed operations with hand-computed results.
module tb_iter_shifter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned STEP  = 4;

  typedef struct {
    logic [WIDTH-1:0] y;
    int               done_cyc;
    int               busy_len;
    int               id;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] b;
  logic [4:0]       shamt;
  logic [1:0]       alufun;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;
  int   busy_run;

  iter_shifter #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .b      (b),
    .shamt  (shamt),
    .alufun (alufun),
    .busy   (busy),
    .done   (done),
    .y      (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse and checks result, latency and busy length.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending operation", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("op%0d_y", e.id), y, e.y);
        check($sformatf("op%0d_latency", e.id), WIDTH'(cyc), WIDTH'(e.done_cyc));
        check($sformatf("op%0d_busy_cycles", e.id), WIDTH'(busy_run), WIDTH'(e.busy_len));
        check($sformatf("op%0d_busy_low_in_done", e.id), WIDTH'(busy), '0);
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end
  end

  // Caller sits just after a negedge; start is accepted at the following posedge.
  task automatic issue(input logic [WIDTH-1:0] bv, input logic [4:0] sv, input logic [1:0] fv,
                       input logic [WIDTH-1:0] yv, input int id);
    exp_t e;
    start  = 1'b1;
    b      = bv;
    shamt  = sv;
    alufun = fv;
    @(posedge clk);
    #1;
    start  = 1'b0;
    // Scramble operands after acceptance; the operation in flight must not see them.
    b      = $urandom;
    shamt  = 5'($urandom);
    alufun = 2'($urandom);
    e.y        = yv;
    e.done_cyc = cyc + int'(sv) / STEP + 1;
    e.busy_len = int'(sv) / STEP + 1;
    e.id       = id;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout: got done=0, expected done=1 within 200 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1 ms");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] y_hold;
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    busy_run = 0;
    rst      = 1'b1;
    start    = 1'b0;
    b        = '0;
    shamt    = '0;
    alufun   = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_y", y, '0);
    check("reset_busy", WIDTH'(busy), '0);
    check("reset_done", WIDTH'(done), '0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'h0000_00F1, 5'd5, 2'b00, 32'h0000_1E20, 1);
    drain();
    issue(32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF, 2);
    drain();
    issue(32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 3);
    drain();

    // Zero shift, then back-to-back start taken in the DONE cycle.
    issue(32'hDEAD_BEEF, 5'd0, 2'b01, 32'hDEAD_BEEF, 4);
    wait_done();
    issue(32'h1234_5678, 5'd8, 2'b00, 32'h3456_7800, 5);
    drain();

    issue(32'h7FFF_0000, 5'd16, 2'b11, 32'h0000_7FFF, 6);
    drain();
    issue(32'hF000_0000, 5'd3, 2'b11, 32'hFE00_0000, 7);
    drain();
    issue(32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 8);
    drain();
    issue(32'h8000_0000, 5'd4, 2'b01, 32'h0800_0000, 9);
    drain();
`ifdef ITER_SHIFTER_ROTATE_EN
    issue(32'h0000_0001, 5'd4, 2'b10, 32'h1000_0000, 10);
    drain();
    issue(32'h1234_5678, 5'd12, 2'b10, 32'h6781_2345, 11);
    drain();
`else
    issue(32'h0000_0001, 5'd4, 2'b10, 32'h0000_0000, 10);
    drain();
    issue(32'h1234_5678, 5'd12, 2'b10, 32'h0001_2345, 11);
    drain();
`endif

    // A start pulsed while busy must be ignored.
    issue(32'h0000_0001, 5'd20, 2'b00, 32'h0010_0000, 12);
    @(negedge clk);
    start  = 1'b1;
    b      = 32'hFFFF_FFFF;
    shamt  = 5'd1;
    alufun = 2'b01;
    @(negedge clk);
    start  = 1'b0;
    drain();

    // Result holds in IDLE.
    y_hold = y;
    repeat (3) @(negedge clk);
    check("idle_y_stable", y, 32'h0010_0000);
    check("idle_y_unchanged", y, y_hold);

    // Reset mid-SHIFT, with a start in the reset cycle that must be dropped.
    issue(32'h0000_0003, 5'd20, 2'b00, 32'h0030_0000, 13);
    @(negedge clk);
    rst    = 1'b1;
    start  = 1'b1;
    b      = 32'hAAAA_AAAA;
    shamt  = 5'd1;
    alufun = 2'b00;
    @(negedge clk);
    exp_q.delete();
    check("midrst_busy", WIDTH'(busy), '0);
    check("midrst_done", WIDTH'(done), '0);
    check("midrst_y", y, '0);
    rst   = 1'b0;
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("postrst_busy", WIDTH'(busy), '0);
    check("postrst_y", y, '0);

    issue(32'h0000_0F00, 5'd7, 2'b01, 32'h0000_001E, 14);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_iter_shifter

// File: doc/iter_shifter.md
ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be a power of two >= 8.
REQ-002 Parameter STEP, default 4, maximum bit positions shifted per cycle; SHALL be a power of two, 1 <= STEP <= WIDTH/2.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; SHALL be sampled only when busy=0.
REQ-006 b  input  WIDTH  operand, captured on an accepted start.
REQ-007 shamt  input  clog2(WIDTH)  shift amount, captured on an accepted start.
REQ-008 alufun  input  2  mode, captured on an accepted start: 00 SLL, 01 SRL, 11 SRA, 10 ROR (see Configuration).
REQ-009 busy  output  1  high while in SHIFT.
REQ-010 done  output  1  one-cycle pulse; y valid in that cycle.
REQ-011 y  output  WIDTH  result register.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; busy SHALL equal (state==SHIFT).
REQ-013 IDLE or DONE with start=1: acc<=b, cnt<=shamt, mode<=alufun, next state SHIFT.
REQ-014 DONE with start=0 -> IDLE; IDLE with start=0 -> IDLE.
REQ-015 SHIFT, cnt>=STEP: acc shifted by STEP in mode, cnt<=cnt-STEP, stay SHIFT.
REQ-016 SHIFT, cnt<STEP (including 0): acc shifted by cnt, cnt<=0, next state DONE.
REQ-017 SHIFT cycles per operation SHALL be floor(shamt/STEP)+1; start accepted at edge N -> done=1 in the cycle after edge N+floor(shamt/STEP)+1.
REQ-018 Fill: SLL and SRL fill vacated bits with 0; SRA fills with acc[WIDTH-1] on every step; ROR wraps bits from LSB into MSB.
REQ-019 y SHALL mirror acc; y is only guaranteed valid while done=1 and SHALL stay stable in IDLE until the next accepted start.
REQ-020 start while busy=1 SHALL be ignored, with no effect on acc, cnt or mode.
REQ-021 start in DONE SHALL be accepted (back-to-back operation), with done=1 still asserted in that DONE cycle.
REQ-022 b, shamt and alufun changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-023 rst=1 at a rising edge SHALL force state IDLE, y/acc=0, cnt=0, busy=0, done=0, regardless of state, including mid-SHIFT.
REQ-024 A start sampled in the same cycle as rst=1 SHALL be discarded.

Configuration
REQ-025 Macro ITER_SHIFTER_ROTATE_EN defined: alufun=10 SHALL perform rotate-right (ROR).
REQ-026 Macro undefined: alufun=10 SHALL behave exactly as SRL and no rotate logic SHALL be present.

Structure
REQ-027 Package shift_pkg SHALL hold the alufun encodings (SLL, SRL, SRA, ROR) and the FSM state typedef.
REQ-028 One sub-module shift_step SHALL implement the combinational single-step shift (acc, amount <= STEP, mode -> shifted acc), instantiated once.

Verification (WIDTH=32, STEP=4, start accepted at edge 0)
REQ-029 SLL, b=0x000000F1, shamt=5 -> y=0x00001E20, done high in the cycle after edge 2, busy high for 2 cycles.
REQ-030 SRA, b=0x80000000, shamt=31 -> y=0xFFFFFFFF, done in the cycle after edge 8; SRL with the same b and shamt -> y=0x00000001.
REQ-031 SRL, b=0xDEADBEEF, shamt=0 -> y=0xDEADBEEF, done in the cycle after edge 1; second start pulsed during DONE -> second result also correct.
REQ-032 SLL shamt=20 started, start re-pulsed with new b while busy -> ignored, first result correct; rst=1 asserted mid-SHIFT -> next cycle busy=0, done=0, y=0, state IDLE.
REQ-033 alufun=10, b=0x00000001, shamt=4 -> y=0x10000000 with ITER_SHIFTER_ROTATE_EN defined, y=0x00000000 without it.
